// File: rtl/itlb_refill.sv
// itlb_refill - hardware page-table walker for the instruction TLB.
//
// On a user-mode iTLB miss the walker reads one PTE from a linear page
// table through a single-outstanding req/ack port, then either fills the
// iTLB (tlb_write strobe) or raises a one-cycle page fault. Fetch must
// stall while walk_busy is high.
//
// Optional feature: define ITLB_REFILL_PERF_EN to add the perf_walks and
// perf_faults counters.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   flush                abort any walk in progress
//   supervisor_mode      misses are accepted only in user mode (0)
//   tlb_miss             miss flag from the iTLB
//   VirtualAddress[31:0] fetch address, captured when a miss is accepted
//   ptbr[19:0]           page-table base (byte address, bits [1:0] ignored)
//   mem_req/mem_addr     PTE read request, held until mem_ack
//   mem_ack/mem_rdata    read completion; PTE bit 31 = valid, [7:0] = PPN
//   tlb_write            one-cycle iTLB fill strobe
//   reg_logic_page       VPN being filled
//   reg_physical_page    PPN being filled
//   walk_busy            walk in progress
//   exc_page_fault       one-cycle page-fault pulse
//   exc_addr[31:0]       faulting virtual address
//   perf_walks/faults    (ITLB_REFILL_PERF_EN only) wrapping event counters
//
// state  | meaning
// IDLE   | waiting for an accepted miss
// REQ    | PTE read outstanding
// WRITE  | iTLB fill strobe cycle
// FAULT  | page-fault pulse cycle
// SETTLE | one dead cycle so the iTLB re-looks-up before a new miss
// DRAIN  | flushed while reading; wait out the ack and discard the data
module itlb_refill #(
    parameter int PT_INDEX_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        supervisor_mode,
    input  logic        tlb_miss,
    input  logic [31:0] VirtualAddress,
    input  logic [19:0] ptbr,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        tlb_write,
    output logic [19:0] reg_logic_page,
    output logic [7:0]  reg_physical_page,
    output logic        walk_busy,
    output logic        exc_page_fault,
    output logic [31:0] exc_addr
`ifdef ITLB_REFILL_PERF_EN
    ,
    output logic [31:0] perf_walks,
    output logic [31:0] perf_faults
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_FAULT,
        S_SETTLE,
        S_DRAIN
    } state_t;

    state_t      state, state_next;
    logic [31:0] va_q;
    logic [19:0] va_vpn;
    logic [19:0] pte_off;
    logic [19:0] pte_addr;
    logic        in_range;
    logic        accept;

    assign va_vpn   = VirtualAddress[31:12];
    assign in_range = (va_vpn >> PT_INDEX_BITS) == 20'd0;
    assign pte_off  = 20'(va_vpn[PT_INDEX_BITS-1:0]) << 2;
    // 20-bit add wraps silently by design.
    assign pte_addr = {ptbr[19:2], 2'b00} + pte_off;

    logic unused_bits;
    assign unused_bits = ^{mem_rdata[30:8], ptbr[1:0]};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tlb_miss && !supervisor_mode && !flush) begin
                    accept     = 1'b1;
                    state_next = in_range ? S_REQ : S_FAULT;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    // A flush landing on the ack cycle just discards the data.
                    if (flush)             state_next = S_IDLE;
                    else if (mem_rdata[31]) state_next = S_WRITE;
                    else                   state_next = S_FAULT;
                end else if (flush) begin
                    state_next = S_DRAIN;
                end
            end
            S_WRITE, S_FAULT: state_next = flush ? S_IDLE : S_SETTLE;
            S_SETTLE:         state_next = S_IDLE;
            S_DRAIN:          if (mem_ack) state_next = S_IDLE;
            default:          state_next = S_IDLE;
        endcase
    end

    // Outputs are registered by decoding the next state, so each one is
    // aligned with the state it describes without a combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            va_q              <= '0;
            mem_req           <= 1'b0;
            mem_addr          <= '0;
            tlb_write         <= 1'b0;
            reg_logic_page    <= '0;
            reg_physical_page <= '0;
            walk_busy         <= 1'b0;
            exc_page_fault    <= 1'b0;
            exc_addr          <= '0;
        end else begin
            state          <= state_next;
            mem_req        <= (state_next == S_REQ) || (state_next == S_DRAIN);
            tlb_write      <= (state_next == S_WRITE);
            exc_page_fault <= (state_next == S_FAULT);
            walk_busy      <= (state_next != S_IDLE);
            if (accept) begin
                va_q     <= VirtualAddress;
                mem_addr <= pte_addr;
            end
            if (state_next == S_WRITE) begin
                reg_logic_page    <= va_q[31:12];
                reg_physical_page <= mem_rdata[7:0];
            end
            // A range fault is taken straight from IDLE, before va_q is loaded.
            if (state_next == S_FAULT)
                exc_addr <= (state == S_IDLE) ? VirtualAddress : va_q;
        end
    end

`ifdef ITLB_REFILL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_walks  <= '0;
            perf_faults <= '0;
        end else begin
            if ((state_next == S_WRITE) || (state_next == S_FAULT))
                perf_walks <= perf_walks + 32'd1;
            if (state_next == S_FAULT)
                perf_faults <= perf_faults + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_itlb_refill.sv
module tb_itlb_refill;

    logic        clk = 1'b0;
    logic        reset, flush, supervisor_mode, tlb_miss;
    logic [31:0] VirtualAddress;
    logic [19:0] ptbr;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        tlb_write;
    logic [19:0] reg_logic_page;
    logic [7:0]  reg_physical_page;
    logic        walk_busy, exc_page_fault;
    logic [31:0] exc_addr;
`ifdef ITLB_REFILL_PERF_EN
    logic [31:0] perf_walks, perf_faults;
`endif

    itlb_refill dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .supervisor_mode   (supervisor_mode),
        .tlb_miss          (tlb_miss),
        .VirtualAddress    (VirtualAddress),
        .ptbr              (ptbr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .tlb_write         (tlb_write),
        .reg_logic_page    (reg_logic_page),
        .reg_physical_page (reg_physical_page),
        .walk_busy         (walk_busy),
        .exc_page_fault    (exc_page_fault),
        .exc_addr          (exc_addr)
`ifdef ITLB_REFILL_PERF_EN
        ,
        .perf_walks        (perf_walks),
        .perf_faults       (perf_faults)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] ptbr;
        logic [31:0] va;
        int          ack_delay;
        logic [31:0] rdata;
        logic        exp_req;
        logic [19:0] exp_addr;
        logic        exp_write;
        logic [19:0] exp_lp;
        logic [7:0]  exp_pp;
        int          exp_busy;
        int          exp_pulse;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " tlb_write"}, 32'(tlb_write), 32'd0);
        chk({tag, " lp"}, 32'(reg_logic_page), 32'd0);
        chk({tag, " pp"}, 32'(reg_physical_page), 32'd0);
        chk({tag, " busy"}, 32'(walk_busy), 32'd0);
        chk({tag, " fault"}, 32'(exc_page_fault), 32'd0);
        chk({tag, " exc_addr"}, exc_addr, 32'd0);
`ifdef ITLB_REFILL_PERF_EN
        chk({tag, " perf_walks"}, perf_walks, 32'd0);
        chk({tag, " perf_faults"}, perf_faults, 32'd0);
`endif
    endtask

    // Runs one miss through to IDLE, acking the PTE read after
    // v.ack_delay extra REQ cycles, and checks the whole response.
    task automatic do_walk(input int idx, input vec_t v);
        int   busy = 0, wr = 0, flt = 0, req_cyc = 0, pulse_at = -1;
        logic req_seen = 1'b0, addr_ok = 1'b1;
        string tag;
        tag = $sformatf("vec%0d", idx);
        ptbr = v.ptbr;
        VirtualAddress = v.va;
        tlb_miss = 1'b1;
        tick();
        tlb_miss = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (walk_busy) busy++;
            if (mem_req) begin
                req_seen = 1'b1;
                if (mem_addr !== v.exp_addr) addr_ok = 1'b0;
            end
            if (tlb_write) begin
                wr++;
                pulse_at = c;
                chk({tag, " lp"}, 32'(reg_logic_page), 32'(v.exp_lp));
                chk({tag, " pp"}, 32'(reg_physical_page), 32'(v.exp_pp));
                chk({tag, " req_during_write"}, 32'(mem_req), 32'd0);
            end
            if (exc_page_fault) begin
                flt++;
                pulse_at = c;
                chk({tag, " exc_addr"}, exc_addr, v.va);
                chk({tag, " req_during_fault"}, 32'(mem_req), 32'd0);
            end
            if (mem_req && req_cyc == v.ack_delay) begin
                mem_ack = 1'b1;
                mem_rdata = v.rdata;
            end
            if (mem_req) req_cyc++;
            tick();
            mem_ack = 1'b0;
            mem_rdata = '0;
        end
        chk({tag, " req_seen"}, 32'(req_seen), 32'(v.exp_req));
        chk({tag, " mem_addr"}, 32'(addr_ok), 32'd1);
        chk({tag, " write_count"}, 32'(wr), v.exp_write ? 32'd1 : 32'd0);
        chk({tag, " fault_count"}, 32'(flt), v.exp_write ? 32'd0 : 32'd1);
        chk({tag, " busy_cycles"}, 32'(busy), 32'(v.exp_busy));
        chk({tag, " pulse_cycle"}, 32'(pulse_at), 32'(v.exp_pulse));
    endtask

    initial begin
        int exp_walks = 0, exp_faults = 0;

        // ptbr, va, ack_delay, rdata, exp_req, exp_addr, exp_write, exp_lp, exp_pp, busy, pulse
        vecs[0] = '{20'h08000, 32'h00003ABC, 1, 32'h80000042, 1'b1, 20'h0800C, 1'b1, 20'h00003, 8'h42, 4, 2};
        vecs[1] = '{20'h08000, 32'h00003ABC, 1, 32'h00000042, 1'b1, 20'h0800C, 1'b0, 20'h00000, 8'h00, 4, 2};
        vecs[2] = '{20'h08000, 32'h00400000, 0, 32'h80000011, 1'b0, 20'h00000, 1'b0, 20'h00000, 8'h00, 2, 0};
        vecs[3] = '{20'h12345, 32'h003FF123, 0, 32'hFFFFFF7E, 1'b1, 20'h13340, 1'b1, 20'h003FF, 8'h7E, 3, 1};
        vecs[4] = '{20'hFFFFC, 32'h00002000, 3, 32'h80000001, 1'b1, 20'h00004, 1'b1, 20'h00002, 8'h01, 6, 4};
        vecs[5] = '{20'h00000, 32'h00001FFF, 0, 32'h7FFFFFFF, 1'b1, 20'h00004, 1'b0, 20'h00000, 8'h00, 3, 1};
        vecs[6] = '{20'h00000, 32'hFFFFF000, 0, 32'h80000001, 1'b0, 20'h00000, 1'b0, 20'h00000, 8'h00, 2, 0};

        reset = 1'b1; flush = 1'b0; supervisor_mode = 1'b0; tlb_miss = 1'b0;
        VirtualAddress = '0; ptbr = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            do_walk(i, vecs[i]);
            exp_walks++;
            if (!vecs[i].exp_write) exp_faults++;
        end
`ifdef ITLB_REFILL_PERF_EN
        chk("perf_walks", perf_walks, 32'(exp_walks));
        chk("perf_faults", perf_faults, 32'(exp_faults));
`endif

        // Flush while the PTE read is outstanding; ack arrives 3 cycles later.
        ptbr = 20'h08000; VirtualAddress = 32'h00003ABC; tlb_miss = 1'b1;
        tick();
        tlb_miss = 1'b0;
        chk("flush req_before", 32'(mem_req), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("flush req_held", 32'(mem_req), 32'd1);
            chk("flush addr_held", 32'(mem_addr), 32'h0800C);
            chk("flush no_write", 32'(tlb_write | exc_page_fault), 32'd0);
            if (c == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h80000042;
            end
            tick();
        end
        mem_ack = 1'b0;
        mem_rdata = '0;
        chk("flush req_drop", 32'(mem_req), 32'd0);
        chk("flush idle", 32'(walk_busy), 32'd0);
        chk("flush no_pulse", 32'(tlb_write | exc_page_fault), 32'd0);
        tick();
        chk("flush stays_quiet", 32'(tlb_write | exc_page_fault | walk_busy), 32'd0);
`ifdef ITLB_REFILL_PERF_EN
        chk("flush perf_walks", perf_walks, 32'(exp_walks));
        chk("flush perf_faults", perf_faults, 32'(exp_faults));
`endif

        // Supervisor-mode miss is ignored.
        supervisor_mode = 1'b1; tlb_miss = 1'b1; VirtualAddress = 32'h00003ABC;
        tick();
        chk("sup busy", 32'(walk_busy), 32'd0);
        tick();
        chk("sup req", 32'(mem_req), 32'd0);
        supervisor_mode = 1'b0; tlb_miss = 1'b0;
        tick();

        // Miss presented during SETTLE is ignored.
        VirtualAddress = 32'h00400000; tlb_miss = 1'b1;
        tick();
        tlb_miss = 1'b0;
        chk("settle fault_pulse", 32'(exc_page_fault), 32'd1);
        tick();
        chk("settle in_settle", 32'(walk_busy), 32'd1);
        VirtualAddress = 32'h00003ABC; tlb_miss = 1'b1;
        tick();
        tlb_miss = 1'b0;
        chk("settle miss_ignored_busy", 32'(walk_busy), 32'd0);
        chk("settle miss_ignored_req", 32'(mem_req), 32'd0);
        tick();

        // Reset in REQ abandons the walk; a later miss walks normally.
        ptbr = 20'h08000; VirtualAddress = 32'h00003ABC; tlb_miss = 1'b1;
        tick();
        tlb_miss = 1'b0;
        chk("rst_mid req_up", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        reset = 1'b0;
        tick();
        do_walk(100, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
